// File: rtl/button_event_fsm.sv
// button_event_fsm: turns debounced button levels into registered press/release/long/repeat pulses.
module button_event_fsm #(
   parameter int N                = 4,
   parameter int LONG_PRESS_TICKS = 100,
   parameter int REPEAT_TICKS     = 20,
   parameter int CNT_W            = $clog2((LONG_PRESS_TICKS > REPEAT_TICKS ? LONG_PRESS_TICKS : REPEAT_TICKS) + 1)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_long_tick,
   input  logic [N-1:0] i_button,
   output logic [N-1:0] o_press,
   output logic [N-1:0] o_release,
   output logic [N-1:0] o_long,
   output logic [N-1:0] o_repeat,
   output logic [N-1:0] o_held
);
   typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_PRESS_TICKS - 1);
   localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_TICKS == 0 ? 0 : REPEAT_TICKS - 1);
   state_t           state [N];
   logic [CNT_W-1:0] cnt   [N];
   logic [N-1:0]     r_prev;
   logic [N-1:0]     rise, fall;
   assign rise = i_button & ~r_prev;
   assign fall = ~i_button & r_prev;
   // a falling edge always wins over a coincident tick, so each branch tests fall first
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_prev    <= '0;
         o_press   <= '0;
         o_release <= '0;
         o_long    <= '0;
         o_repeat  <= '0;
         o_held    <= '0;
         for (int c = 0; c < N; c++) begin
            state[c] <= IDLE;
            cnt[c]   <= '0;
         end
      end else begin
         r_prev    <= i_button;
         o_press   <= '0;
         o_release <= '0;
         o_long    <= '0;
         o_repeat  <= '0;
         o_held    <= '0;
         for (int c = 0; c < N; c++) begin
            case (state[c])
               IDLE:
                  if (rise[c]) begin
                     state[c]   <= SHORT;
                     cnt[c]     <= '0;
                     o_press[c] <= 1'b1;
                  end
               SHORT:
                  if (fall[c]) begin
                     state[c]     <= IDLE;
                     cnt[c]       <= '0;
                     o_release[c] <= 1'b1;
                  end else if (i_long_tick) begin
                     if (cnt[c] == LONG_MAX) begin
                        state[c]  <= LONG;
                        cnt[c]    <= '0;
                        o_long[c] <= 1'b1;
                        o_held[c] <= 1'b1;
                     end else
                        cnt[c] <= cnt[c] + 1'b1;
                  end
               LONG:
                  if (fall[c]) begin
                     state[c]     <= IDLE;
                     cnt[c]       <= '0;
                     o_release[c] <= 1'b1;
                  end else begin
                     o_held[c] <= 1'b1;
                     if (REPEAT_TICKS != 0 && i_long_tick) begin
                        if (cnt[c] == REP_MAX) begin
                           cnt[c]      <= '0;
                           o_repeat[c] <= 1'b1;
                        end else
                           cnt[c] <= cnt[c] + 1'b1;
                     end
                  end
               default: state[c] <= IDLE;
            endcase
         end
      end
endmodule
